ov_cam_sccb_arbiter: RTL
========================

OV_CAM_SCCB_ARBITER -- requirements
Module: ov_cam_sccb_arbiter

Interface
REQ-001 Parameter REGADDR_WIDTH, default 16; SCCB register address width (16 for OV5640, 8 otherwise).
REQ-002 Parameter TIMEOUT_CYCLES, default 4096; clk cycles allowed between sccb_start and sccb_done before abort.
REQ-003 clk  in  1  single clock; the SCCB-rate clock that also drives the SCCB master.
REQ-004 resetn  in  1  asynchronous, active-low reset.
REQ-005 req[1:0]  in  2  per-requester transaction request; requester 0 is the init sequencer, requester 1 is runtime register access.
REQ-006 rw[1:0]  in  2  per-requester direction; 1 = read, 0 = write.
REQ-007 devaddr0/devaddr1  in  8 each  per-requester device address.
REQ-008 regaddr0/regaddr1  in  REGADDR_WIDTH each  per-requester register address.
REQ-009 wrdata0/wrdata1  in  8 each  per-requester write data.
REQ-010 ack[1:0]  out  2  one-cycle completion pulse to the granted requester.
REQ-011 err  out  1  valid with ack; 1 = timeout abort.
REQ-012 rddata  out  8  read data, valid with ack for read transactions.
REQ-013 busy  out  1  high whenever state is not IDLE.
REQ-014 sccb_start  out  1  one-cycle start pulse to the SCCB master.
REQ-015 sccb_devaddr/sccb_regaddr/sccb_wrdata  out  8/REGADDR_WIDTH/8  latched payload to the SCCB master (read flag is carried in sccb_devaddr bit 0).
REQ-016 sccb_done  in  1  one-cycle completion pulse from the SCCB master.
REQ-017 sccb_rddata  in  8  read data from the SCCB master, valid when sccb_done pulses.

Function
REQ-018 The FSM SHALL have exactly four states: IDLE, LAUNCH, WAIT, RESP.
REQ-019 In IDLE with any req high, the block SHALL grant one requester, latch its payload, and enter LAUNCH on the next edge.
REQ-020 Arbitration SHALL be round-robin: on contention, grant the requester not granted last; after reset, requester 0 wins the first contention.
REQ-021 The latched sccb_devaddr SHALL be {devaddrN[7:1], rwN}.
REQ-022 LAUNCH SHALL assert sccb_start for exactly one cycle, clear the timeout counter, then enter WAIT.
REQ-023 In WAIT, when sccb_done is 1, rddata SHALL latch sccb_rddata, err SHALL be cleared, and the FSM SHALL enter RESP.
REQ-024 In WAIT, the timeout counter SHALL increment each cycle; when it reaches TIMEOUT_CYCLES-1 without sccb_done, err SHALL be set and the FSM SHALL enter RESP.
REQ-025 In RESP, ack[grant] SHALL be high for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-026 Requesters SHALL hold req and the payload until ack. The block SHALL sample the payload only in IDLE; later changes SHALL NOT affect the transaction in flight.
REQ-027 A req that falls while granted SHALL NOT abort the transaction; ack SHALL still be issued.
REQ-028 An sccb_done pulse seen outside WAIT SHALL be ignored.
REQ-029 Latency from grant to sccb_start SHALL be 1 cycle. Latency from sccb_done to ack SHALL be 1 cycle. A back-to-back grant SHALL occur no earlier than 1 cycle after ack (IDLE cycle).
REQ-030 rddata and err SHALL hold their values until the next RESP.

Reset
REQ-031 Asserting resetn low SHALL, asynchronously, set the state to IDLE, the last-grant pointer to 1, and the timeout counter to 0.
REQ-032 The same reset SHALL drive ack, err, sccb_start, and busy to 0, and rddata, sccb_devaddr, sccb_regaddr, and sccb_wrdata to 0.
REQ-033 Reset mid-transaction SHALL drop the transaction without issuing ack. After release, the block SHALL start in IDLE and accept requests immediately.

Structure
REQ-034 The state encoding and the REGADDR_WIDTH selection rule (16 when CAMERA_MODEL = 5640, else 8) SHALL live in the shared OV_CAM package.
REQ-035 The round-robin grant logic SHALL be one sub-module, ov_cam_rr_arbiter2 (req[1:0], last grant → one-hot grant).

Verification
REQ-036 Single write, requester 0: req0 with dev 0x78, reg 0x3008, data 0x82; sccb_done 10 cycles after start → sccb_devaddr 0x78, one sccb_start pulse, ack[0] one cycle later, err 0.
REQ-037 Read, requester 1: rw1=1, dev 0x78; sccb_done with sccb_rddata 0x56 → sccb_devaddr 0x79, rddata 0x56 with ack[1].
REQ-038 Contention: both req high from reset → grant order 0, 1, 0, 1 over four transactions; payloads never mixed.
REQ-039 Timeout: TIMEOUT_CYCLES=16, sccb_done never arrives → ack with err 1 exactly 16 cycles after sccb_start.
REQ-040 Reset mid-WAIT: resetn low for 2 cycles → no ack, busy 0. Next req → normal transaction.
REQ-041 Spurious sccb_done in IDLE, then payload change after grant → no ack, and the SCCB outputs keep the originally latched values.

Source files
------------

// File: rtl/ov_cam_pkg.sv
// Shared OV camera definitions: SCCB arbiter state encoding and register-address width selection.
package ov_cam_pkg;

   // Arbiter transaction states
   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StLaunch = 2'd1,
      StWait   = 2'd2,
      StResp   = 2'd3
   } sccb_state_e;

   // Sensor targeted by this build; OV5640 uses 16-bit register addresses
   localparam int unsigned CAMERA_MODEL = 5640;

   function automatic int unsigned regaddr_width_for(input int unsigned model);
      return (model == 5640) ? 16 : 8;
   endfunction

   localparam int unsigned REGADDR_WIDTH_DFLT = regaddr_width_for(CAMERA_MODEL);

endpackage

// File: rtl/ov_cam_rr_arbiter2.sv
// Two-way round-robin grant: on contention the requester not granted last wins.
module ov_cam_rr_arbiter2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] grant
);

   // One-hot grant from current requests and last-grant pointer
   always_comb begin
      grant = 2'b00;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

endmodule

// File: rtl/ov_cam_sccb_arbiter.sv
// Arbitrates two requesters (init sequencer, runtime access) onto a single SCCB master,
// with a per-transaction timeout and one-cycle ack back to the granted requester.
module ov_cam_sccb_arbiter
   import ov_cam_pkg::*;
#(
   parameter int unsigned REGADDR_WIDTH  = REGADDR_WIDTH_DFLT,
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic [1:0]               req,
   input  logic [1:0]               rw,
   input  logic [7:0]               devaddr0,
   input  logic [7:0]               devaddr1,
   input  logic [REGADDR_WIDTH-1:0] regaddr0,
   input  logic [REGADDR_WIDTH-1:0] regaddr1,
   input  logic [7:0]               wrdata0,
   input  logic [7:0]               wrdata1,
   output logic [1:0]               ack,
   output logic                     err,
   output logic [7:0]               rddata,
   output logic                     busy,
   output logic                     sccb_start,
   output logic [7:0]               sccb_devaddr,
   output logic [REGADDR_WIDTH-1:0] sccb_regaddr,
   output logic [7:0]               sccb_wrdata,
   input  logic                     sccb_done,
   input  logic [7:0]               sccb_rddata
);

   localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   // Abort on the WAIT cycle whose increment brings the counter to TIMEOUT_CYCLES-1
   localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYCLES - 2);

   sccb_state_e      state;
   logic [1:0]       grant;
   logic [1:0]       grant_q;
   logic             last_q;
   logic [CntW-1:0]  tcnt_q;

   ov_cam_rr_arbiter2 u_rr (
      .req   (req),
      .last  (last_q),
      .grant (grant)
   );

   assign busy = (state != StIdle);

   // Transaction FSM with registered handshake and payload outputs
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state        <= StIdle;
         grant_q      <= 2'b00;
         last_q       <= 1'b1;
         tcnt_q       <= '0;
         ack          <= 2'b00;
         err          <= 1'b0;
         rddata       <= 8'h00;
         sccb_start   <= 1'b0;
         sccb_devaddr <= 8'h00;
         sccb_regaddr <= '0;
         sccb_wrdata  <= 8'h00;
      end else begin
         sccb_start <= 1'b0;
         ack        <= 2'b00;
         unique case (state)
            StIdle: begin
               if (grant != 2'b00) begin
                  grant_q    <= grant;
                  last_q     <= grant[1];
                  sccb_start <= 1'b1;
                  state      <= StLaunch;
                  if (grant[1]) begin
                     sccb_devaddr <= {devaddr1[7:1], rw[1]};
                     sccb_regaddr <= regaddr1;
                     sccb_wrdata  <= wrdata1;
                  end else begin
                     sccb_devaddr <= {devaddr0[7:1], rw[0]};
                     sccb_regaddr <= regaddr0;
                     sccb_wrdata  <= wrdata0;
                  end
               end
            end
            StLaunch: begin
               tcnt_q <= '0;
               state  <= StWait;
            end
            StWait: begin
               // Completion takes priority over a coincident timeout
               if (sccb_done) begin
                  rddata <= sccb_rddata;
                  err    <= 1'b0;
                  ack    <= grant_q;
                  state  <= StResp;
               end else if (tcnt_q == TimeoutLast) begin
                  tcnt_q <= tcnt_q + CntW'(1);
                  err    <= 1'b1;
                  ack    <= grant_q;
                  state  <= StResp;
               end else begin
                  tcnt_q <= tcnt_q + CntW'(1);
               end
            end
            StResp: begin
               state <= StIdle;
            end
            default: begin
               state <= StIdle;
            end
         endcase
      end
   end

endmodule
